// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master arbiter and strobe sequencer for one async SRAM.
// Port 0 (VGA) has read-only fixed priority, bounded by a starvation guard for port 1 (CPU, read/write).
// Ports: clk, rst (sync, active-high), m0_* (port-0 req/addr/ack/rdata),
//        m1_* (port-1 req/we/addr/wdata/ack/rdata), sram_* pins (addr, dq_o/dq_oe/dq_i, ce/oen/wen active-low).
module sram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 48,
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce,
  output logic              sram_oen,
  output logic              sram_wen
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, WREC, ACK
  } state_t;

  localparam int CMAX  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int SW    = $clog2(MAX_STARVE + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              ce_q, ce_d;
  logic              oen_q, oen_d;
  logic              wen_q, wen_d;
  logic              oe_q, oe_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              m0_win;
  logic              starved;

  assign starved = m1_req && (starve_q == SW'(MAX_STARVE));
  assign m0_win  = m0_req && !starved;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    dq_o_d   = dq_o_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_win) begin
          sel_d    = 1'b0;
          addr_d   = m0_addr;
          state_d  = READ;
          starve_d = m1_req ? starve_q + SW'(1) : '0;
        end else if (m1_req) begin
          sel_d    = 1'b1;
          addr_d   = m1_addr;
          dq_o_d   = m1_wdata;
          state_d  = m1_we ? WRITE : READ;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      READ: begin
        if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
          if (sel_q) rd1_d = sram_dq_i;
          else       rd0_d = sram_dq_i;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) state_d = WREC;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      WREC:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered, so they are decoded from the state being entered.
  always_comb begin
    ce_d   = !(state_d inside {READ, WRITE, WREC});
    oen_d  = (state_d != READ);
    wen_d  = (state_d != WRITE);
    oe_d   = (state_d inside {WRITE, WREC});
    ack0_d = (state_d == ACK) && !sel_d;
    ack1_d = (state_d == ACK) && sel_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      dq_o_q   <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      ce_q     <= 1'b1;
      oen_q    <= 1'b1;
      wen_q    <= 1'b1;
      oe_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      dq_o_q   <= dq_o_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      ce_q     <= ce_d;
      oen_q    <= oen_d;
      wen_q    <= wen_d;
      oe_q     <= oe_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign m0_ack     = ack0_q;
  assign m1_ack     = ack1_q;
  assign m0_rdata   = rd0_q;
  assign m1_rdata   = rd1_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = oe_q;
  assign sram_ce    = ce_q;
  assign sram_oen   = oen_q;
  assign sram_wen   = wen_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: bench for sram_arbiter with a timeline model of each access.
// Covers default build (model-checked every cycle) and an RD=1/WR=3 build.
module tb_sram_arbiter;

  localparam int RD   = 2;
  localparam int WR   = 2;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m1_we;
  logic [19:0] m0_addr, m1_addr;
  logic [47:0] m1_wdata;
  logic        m0_ack, m1_ack;
  logic [47:0] m0_rdata, m1_rdata;
  logic [19:0] sram_addr;
  logic [47:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce, sram_oen, sram_wen;

  logic        b_m1_req, b_m1_we;
  logic [19:0] b_m1_addr;
  logic [47:0] b_m1_wdata;
  logic        b_m0_ack, b_m1_ack;
  logic [47:0] b_m0_rdata, b_m1_rdata;
  logic [19:0] b_sram_addr;
  logic [47:0] b_sram_dq_o, b_sram_dq_i;
  logic        b_sram_dq_oe, b_sram_ce, b_sram_oen, b_sram_wen;

  logic [47:0] mem [256];
  logic [47:0] shadow [256];

  bit          busy;
  int          k;
  int          win;
  bit          wr;
  int          st;
  logic [19:0] maddr;
  logic [47:0] mwd, r0, r1;
  int          glog[$];
  int          alog[$];
  bit          auto0;
  int          tests;
  int          fails;

  always #5 clk = ~clk;

  sram_arbiter u0 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce(sram_ce), .sram_oen(sram_oen),
    .sram_wen(sram_wen)
  );

  sram_arbiter #(.RD_CYCLES(1), .WR_CYCLES(3)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(1'b0), .m0_addr(20'h0),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we),
    .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .sram_addr(b_sram_addr), .sram_dq_o(b_sram_dq_o),
    .sram_dq_oe(b_sram_dq_oe), .sram_dq_i(b_sram_dq_i),
    .sram_ce(b_sram_ce), .sram_oen(b_sram_oen),
    .sram_wen(b_sram_wen)
  );

  assign sram_dq_i = (!sram_ce && !sram_oen) ? mem[sram_addr[7:0]] : 48'h0;
  assign b_sram_dq_i = (!b_sram_ce && !b_sram_oen) ? 48'h1234_5678_9ABC : 48'h0;

  always @(posedge clk)
    if (!sram_ce && !sram_wen) mem[sram_addr[7:0]] <= sram_dq_o;

  // Access model: after a grant, cycle k of the access fixes the pins.
  always @(posedge clk) begin : model
    int g, tot;
    if (rst) begin
      busy = 0; k = 0; st = 0; win = 0; wr = 0;
      maddr = '0; mwd = '0; r0 = '0; r1 = '0;
    end else if (!busy) begin
      g = 2;
      if (m0_req && !(m1_req && st == MAXS)) g = 0;
      else if (m1_req) g = 1;
      if (g == 0 && m1_req) st++;
      else st = 0;
      if (g != 2) begin
        busy = 1; k = 1; win = g;
        wr = (g == 1) && m1_we;
        maddr = (g == 1) ? m1_addr : m0_addr;
        if (g == 1) mwd = m1_wdata;
        glog.push_back(g);
      end
    end else begin
      tot = wr ? WR + 2 : RD + 1;
      if (!wr && k == RD) begin
        if (win == 1) r1 = shadow[maddr[7:0]];
        else r0 = shadow[maddr[7:0]];
      end
      if (wr && k <= WR) shadow[maddr[7:0]] = mwd;
      if (k == tot) begin busy = 0; k = 0; end
      else k++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mcheck();
    int tot;
    logic [5:0] e, a;
    logic e_oe;
    tot = wr ? WR + 2 : RD + 1;
    e_oe = busy && wr && k <= WR + 1;
    e = {!(busy && k < tot), !(busy && !wr && k <= RD),
         !(busy && wr && k <= WR), e_oe,
         busy && k == tot && win == 0, busy && k == tot && win == 1};
    a = {sram_ce, sram_oen, sram_wen, sram_dq_oe, m0_ack, m1_ack};
    tests++;
    if (a !== e || sram_addr !== maddr || m0_rdata !== r0 ||
        m1_rdata !== r1 || (e_oe && sram_dq_o !== mwd)) begin
      fails++;
      $display("FAIL model t=%0t pins=%b exp=%b addr=%h exp=%h rd0=%h exp=%h rd1=%h exp=%h dq=%h exp=%h",
               $time, a, e, sram_addr, maddr, m0_rdata, r0,
               m1_rdata, r1, sram_dq_o, mwd);
    end
    tests++;
    if ((!sram_oen && !sram_wen) || (sram_dq_oe && !sram_oen) ||
        (!b_sram_oen && !b_sram_wen) || (b_sram_dq_oe && !b_sram_oen)) begin
      fails++;
      $display("FAIL strobe_excl: oen/wen/oe=%b%b%b b=%b%b%b expected no overlap",
               sram_oen, sram_wen, sram_dq_oe,
               b_sram_oen, b_sram_wen, b_sram_dq_oe);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mcheck();
    if (m0_ack) begin
      alog.push_back(0);
      if (auto0) m0_req = 0;
    end
    if (m1_ack) begin
      alog.push_back(1);
      m1_req = 0;
    end
  endtask

  task automatic p1(input bit we, input logic [19:0] a, input logic [47:0] d,
                    output int n, output int nw, output int nd);
    step();
    m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d;
    n = 0; nw = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (!sram_wen) nw++;
      if (sram_dq_oe) nd++;
      if (m1_ack) break;
    end
    m1_req = 0;
  endtask

  task automatic p0(input logic [19:0] a, output int n, output int nr);
    step();
    auto0 = 1; m0_req = 1; m0_addr = a;
    n = 0; nr = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (!sram_oen) nr++;
      if (m0_ack) break;
    end
    m0_req = 0;
  endtask

  task automatic bacc(input bit we, output int n, output int nw);
    step();
    b_m1_req = 1; b_m1_we = we; b_m1_addr = 20'h00042;
    b_m1_wdata = 48'hCAFE_0000_BEEF;
    n = 0; nw = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (!b_sram_wen) nw++;
      if (b_m1_ack) break;
    end
    b_m1_req = 0;
  endtask

  initial begin
    int n, nw, nd, ab, gb;
    int exp4 [6];
    exp4[0] = 0; exp4[1] = 0; exp4[2] = 0;
    exp4[3] = 0; exp4[4] = 1; exp4[5] = 0;
    tests = 0; fails = 0; auto0 = 1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {40'hDEAD_BEEF_00, 8'(i)};
      shadow[i] = {40'hDEAD_BEEF_00, 8'(i)};
    end
    rst = 1;
    m0_req = 0; m0_addr = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0; b_m1_wdata = '0;
    repeat (3) step();
    chk("rst_strobes", {sram_ce, sram_oen, sram_wen, sram_dq_oe}, 4'b1110);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    rst = 0;

    p1(1, 20'h00010, 48'hA5A5_0000_5A5A, n, nw, nd);
    chk("wr_ack_lat", n, 4);
    chk("wr_wen_cycles", nw, 2);
    chk("wr_oe_cycles", nd, 3);
    p1(0, 20'h00010, 48'h0, n, nw, nd);
    chk("rd1_ack_lat", n, 3);
    chk("rd1_data", m1_rdata, 48'hA5A5_0000_5A5A);

    p0(20'h12345, n, nw);
    chk("rd0_ack_lat", n, 3);
    chk("rd0_oen_cycles", nw, 2);
    chk("rd0_data", m0_rdata, 48'hDEAD_BEEF_0045);
    repeat (3) step();
    chk("rd0_hold", m0_rdata, 48'hDEAD_BEEF_0045);

    step();
    ab = alog.size(); gb = glog.size();
    auto0 = 1;
    m0_req = 1; m0_addr = 20'h00020;
    m1_req = 1; m1_we = 0; m1_addr = 20'h00030;
    for (int i = 0; i < 30 && alog.size() < ab + 2; i++) step();
    m0_req = 0; m1_req = 0;
    chk("simul_cnt", alog.size(), ab + 2);
    if (alog.size() >= ab + 2) begin
      chk("simul_first", alog[ab], 0);
      chk("simul_second", alog[ab + 1], 1);
    end
    if (glog.size() >= gb + 2)
      chk("simul_model", {glog[gb], glog[gb + 1]}, {32'd0, 32'd1});

    step();
    ab = alog.size(); gb = glog.size();
    auto0 = 0;
    m0_req = 1; m0_addr = 20'h00020;
    m1_req = 1; m1_we = 0; m1_addr = 20'h00030;
    for (int i = 0; i < 80 && alog.size() < ab + 6; i++) step();
    m0_req = 0; m1_req = 0; auto0 = 1;
    chk("starve_cnt", alog.size(), ab + 6);
    for (int i = 0; i < 6; i++) begin
      if (alog.size() > ab + i) chk($sformatf("starve_ack%0d", i), alog[ab + i], exp4[i]);
      if (glog.size() > gb + i) chk($sformatf("starve_model%0d", i), glog[gb + i], exp4[i]);
    end

    step();
    m1_req = 1; m1_we = 1; m1_addr = 20'h00077; m1_wdata = 48'h1111_2222_3333;
    step();
    chk("rstw_inwrite", sram_wen, 0);
    rst = 1; m1_req = 0;
    ab = alog.size();
    step();
    chk("rstw_strobes", {sram_ce, sram_oen, sram_wen, sram_dq_oe}, 4'b1110);
    chk("rstw_acks", {m0_ack, m1_ack}, 2'b00);
    rst = 0;
    repeat (6) step();
    chk("rstw_noack", alog.size(), ab);
    p0(20'h12345, n, nw);
    chk("rstw_idle_lat", n, 3);

    bacc(1, n, nw);
    chk("b_wr_ack_lat", n, 5);
    chk("b_wr_wen_cycles", nw, 3);
    bacc(0, n, nw);
    chk("b_rd_ack_lat", n, 2);
    chk("b_rd_data", b_m1_rdata, 48'h1234_5678_9ABC);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external asynchronous SRAM (20-bit address, 48-bit data) between two masters: the VGA frame reader (port 0, read-only, real-time) and the CPU bus bridge (port 1, read/write). It sits between those masters and the top-level SRAM pins. It sequences each access through chip-enable, output-enable and write-enable phases with programmable cycle counts. Fixed priority to port 0 is bounded by a starvation guard for port 1.

## Interface
Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 48, SRAM data width
- RD_CYCLES, 2, cycles oen/ce held low per read (≥1)
- WR_CYCLES, 2, cycles wen held low per write (≥1)
- MAX_STARVE, 4, consecutive port-0 grants allowed while port 1 waits (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  port 0 read request; held until m0_ack
- m0_addr  in  ADDR_W  port 0 word address
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  port 0 read data, valid with m0_ack, held until next port-0 read
- m1_req  in  1  port 1 request; held until m1_ack
- m1_we  in  1  1 = write, 0 = read
- m1_addr  in  ADDR_W  port 1 word address
- m1_wdata  in  DATA_W  port 1 write data
- m1_ack  out  1  one-cycle completion pulse
- m1_rdata  out  DATA_W  port 1 read data, valid with m1_ack, held until next port-1 read
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o  out  DATA_W  write data to the top-level tristate
- sram_dq_oe  out  1  tristate drive enable
- sram_dq_i  in  DATA_W  data from the SRAM pins
- sram_ce, sram_oen, sram_wen  out  1 each  active-low SRAM strobes

## Operation
- All outputs are registered.
- Reset values:
  - sram_ce = sram_oen = sram_wen = 1
  - sram_dq_oe = 0
  - sram_addr, sram_dq_o = 0
  - m0_ack = m1_ack = 0
  - m0_rdata, m1_rdata = 0
  - state = IDLE
  - starve_cnt = 0
- States: IDLE, READ, WRITE, WREC, ACK.
- IDLE:
  - All strobes high, dq_oe = 0.
  - If any request is high, select a winner and latch address, we and wdata. Port 0 is always a read.
  - A read goes to READ and a write goes to WRITE, with cnt = 0.
- Arbitration:
  - Port 0 wins if m0_req is high, unless m1_req is high and starve_cnt == MAX_STARVE.
  - Otherwise port 1 wins if m1_req is high.
  - starve_cnt increments on a port-0 grant while m1_req is high.
  - starve_cnt clears on a port-1 grant, and in any IDLE cycle where m1_req is low.
- READ:
  - ce = 0, oen = 0, wen = 1.
  - Lasts RD_CYCLES cycles.
  - In the last cycle, capture sram_dq_i into the winner's rdata register, then go to ACK.
- WRITE:
  - ce = 0, wen = 0, oen = 1, dq_oe = 1, dq_o = latched wdata.
  - Lasts WR_CYCLES cycles, then goes to WREC.
- WREC: wen = 1, ce = 0, dq_oe = 1 with data still driven for one cycle (hold time), then ACK.
- ACK:
  - Strobes high, dq_oe = 0.
  - Assert the winner's ack for exactly one cycle, then go to IDLE.
- oen and wen are never low in the same cycle. dq_oe is never 1 while oen = 0.
- A requester dropping req before its ack is illegal. The access still completes and ack still pulses.
- A request still high in the cycle after ack is treated as a new request and re-arbitrated.
- m1_rdata is unchanged by writes.
- rst asserted mid-access:
  - Next cycle all outputs take reset values.
  - No ack is issued and no rdata is updated.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- Read: strobes low in cycles 1..RD_CYCLES; ack in cycle RD_CYCLES+1; latency RD_CYCLES+1.
- Write: wen low in cycles 1..WR_CYCLES; WREC in cycle WR_CYCLES+1; ack in cycle WR_CYCLES+2.
- Back-to-back read throughput is one access per RD_CYCLES+2 cycles, because IDLE is mandatory between accesses.
- The address is stable from the first strobe cycle through WREC/ACK.

## Test plan
- Reset, then a single port-1 write (addr 0x00010, data 0xA5A5_0000_5A5A, defaults): wen low for 2 cycles, dq_oe high for 3 cycles, m1_ack at cycle 4. A following read of the same address (SRAM model) returns the same data with m1_ack at cycle 3.
- Port-0 read of 0x12345 with defaults: sram_oen low in cycles 1–2, m0_ack at cycle 3, m0_rdata equals the model word and holds after ack.
- Simultaneous m0_req and m1_req in the same cycle: port 0 granted first, port 1 granted in the next arbitration.
- m0_req held continuously with m1_req high: exactly 4 port-0 grants, then one port-1 grant, then port 0 resumes.
- rst asserted in cycle 1 of a WRITE: all strobes high and dq_oe = 0 next cycle, no ack pulses, state IDLE.
- RD_CYCLES = 1, WR_CYCLES = 3 build: check the read ack at cycle 2 and the write ack at cycle 5. Assert in every cycle that oen and wen are never both low.
